// File: rtl/spiral_walk_if.sv
// spiral_walk_if
// Groups the start/handshake/status signals of the spiral coordinate
// sequencer so that they can be passed as one port.
//   master : the sequencer; drives valid, x, y, last, busy, done and
//            receives start and ready.
//   slave  : the consumer and controller side; drives start and ready.
// Parameter GRID_W sets the coordinate width and must match the
// GRID_W of the sequencer that this interface is connected to.
interface spiral_walk_if #(
   parameter int GRID_W = 3
);
   logic              start;
   logic              ready;
   logic              valid;
   logic [GRID_W-1:0] x;
   logic [GRID_W-1:0] y;
   logic              last;
   logic              busy;
   logic              done;

   modport master (
      input  start,
      input  ready,
      output valid,
      output x,
      output y,
      output last,
      output busy,
      output done
   );

   modport slave (
      output start,
      output ready,
      input  valid,
      input  x,
      input  y,
      input  last,
      input  busy,
      input  done
   );
endinterface

// File: rtl/spiral_walk_ctrl.sv
// spiral_walk_ctrl
// Walks an N x N grid (N = 2**GRID_W) in spiral order. The walk starts at
// the top-left corner and moves inward. It emits one coordinate for each
// accepted valid/ready beat. After the final beat is accepted, done pulses
// for one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    spiral_walk_if.master
//          start, ready               : inputs
//          valid, x, y, last, busy,
//          done                       : outputs
// Build option:
//   SPIRAL_CCW_EN  when defined, the walk runs counter-clockwise. This is
//                  the clockwise sequence with x and y swapped.
module spiral_walk_ctrl #(
   parameter int GRID_W = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   spiral_walk_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP} dir_t;

   localparam logic [GRID_W-1:0]   COORD_MAX = '1;
   localparam logic [GRID_W-1:0]   COORD_ONE = GRID_W'(1);
   localparam logic [2*GRID_W-1:0] CNT_LAST  = '1;
   localparam logic [2*GRID_W-1:0] CNT_ONE   = (2*GRID_W)'(1);

`ifdef SPIRAL_CCW_EN
   localparam dir_t DIR_INIT = DIR_DOWN;
`else
   localparam dir_t DIR_INIT = DIR_RIGHT;
`endif

   state_t              state_q, state_d;
   dir_t                dir_q, dir_d;
   logic [GRID_W-1:0]   x_q, x_d, y_q, y_d;
   logic [GRID_W-1:0]   top_q, top_d, bot_q, bot_d;
   logic [GRID_W-1:0]   left_q, left_d, right_q, right_d;
   logic [2*GRID_W-1:0] count_q, count_d;
   logic                accept;
   logic                last_beat;

   // valid is high in RUN only. That lets acceptance depend on ready and the state.
   assign accept    = (state_q == S_RUN) && bus.ready;
   assign last_beat = (state_q == S_RUN) && (count_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. start only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start)           state_d = S_RUN;
         S_RUN:   if (accept && last_beat) state_d = S_DONE;
         S_DONE:                           state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Walk registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         top_q   <= '0;
         left_q  <= '0;
         bot_q   <= COORD_MAX;
         right_q <= COORD_MAX;
         dir_q   <= DIR_INIT;
         count_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         top_q   <= top_d;
         left_q  <= left_d;
         bot_q   <= bot_d;
         right_q <= right_d;
         dir_q   <= dir_d;
         count_q <= count_d;
      end
   end

   // Moves to the next coordinate on every accepted beat except the last one.
   // When the walk reaches a bound, it turns. The bound it just finished is
   // pulled inward and the first step is taken in the new direction.
   // Only count ends the walk, so the bounds never need a crossing check.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      top_d   = top_q;
      left_d  = left_q;
      bot_d   = bot_q;
      right_d = right_q;
      dir_d   = dir_q;
      count_d = count_q;
      if ((state_q == S_IDLE) && bus.start) begin
         x_d     = '0;
         y_d     = '0;
         top_d   = '0;
         left_d  = '0;
         bot_d   = COORD_MAX;
         right_d = COORD_MAX;
         dir_d   = DIR_INIT;
         count_d = '0;
      end else if (accept && !last_beat) begin
         count_d = count_q + CNT_ONE;
`ifdef SPIRAL_CCW_EN
         case (dir_q)
            DIR_DOWN:
               if (y_q == bot_q) begin
                  left_d = left_q + COORD_ONE; dir_d = DIR_RIGHT; x_d = x_q + COORD_ONE;
               end else y_d = y_q + COORD_ONE;
            DIR_RIGHT:
               if (x_q == right_q) begin
                  bot_d = bot_q - COORD_ONE; dir_d = DIR_UP; y_d = y_q - COORD_ONE;
               end else x_d = x_q + COORD_ONE;
            DIR_UP:
               if (y_q == top_q) begin
                  right_d = right_q - COORD_ONE; dir_d = DIR_LEFT; x_d = x_q - COORD_ONE;
               end else y_d = y_q - COORD_ONE;
            default:
               if (x_q == left_q) begin
                  top_d = top_q + COORD_ONE; dir_d = DIR_DOWN; y_d = y_q + COORD_ONE;
               end else x_d = x_q - COORD_ONE;
         endcase
`else
         case (dir_q)
            DIR_RIGHT:
               if (x_q == right_q) begin
                  top_d = top_q + COORD_ONE; dir_d = DIR_DOWN; y_d = y_q + COORD_ONE;
               end else x_d = x_q + COORD_ONE;
            DIR_DOWN:
               if (y_q == bot_q) begin
                  right_d = right_q - COORD_ONE; dir_d = DIR_LEFT; x_d = x_q - COORD_ONE;
               end else y_d = y_q + COORD_ONE;
            DIR_LEFT:
               if (x_q == left_q) begin
                  bot_d = bot_q - COORD_ONE; dir_d = DIR_UP; y_d = y_q - COORD_ONE;
               end else x_d = x_q - COORD_ONE;
            default:
               if (y_q == top_q) begin
                  left_d = left_q + COORD_ONE; dir_d = DIR_RIGHT; x_d = x_q + COORD_ONE;
               end else y_d = y_q - COORD_ONE;
         endcase
`endif
      end
   end

   // Outputs come only from registers, so ready has no combinational path to them.
   always_comb begin
      bus.valid = (state_q == S_RUN);
      bus.busy  = (state_q == S_RUN) || (state_q == S_DONE);
      bus.done  = (state_q == S_DONE);
      bus.last  = last_beat;
      bus.x     = x_q;
      bus.y     = y_q;
   end

endmodule

// File: tb/tb_spiral_walk_ctrl.sv
// tb_spiral_walk_ctrl
// Drives three sequencers with GRID_W = 1, 2 and 3 through one selectable
// stimulus path. A separate visited-cell turning walk builds the expected
// coordinates. Those expectations are queued when a walk starts and are
// compared on every cycle in which the sequencer presents a coordinate.
module tb_spiral_walk_ctrl;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start_s;
   logic ready_s;
   int   sel;
   int   errors = 0;
   int   checks = 0;
   beat_t exp_q[$];

   logic [2:0] mx, my;
   logic       mvalid, mlast, mbusy, mdone;

   always #5 clk = ~clk;

   spiral_walk_if #(.GRID_W(1)) if1 ();
   spiral_walk_if #(.GRID_W(2)) if2 ();
   spiral_walk_if #(.GRID_W(3)) if3 ();

   assign if1.start = (sel == 1) ? start_s : 1'b0;
   assign if2.start = (sel == 2) ? start_s : 1'b0;
   assign if3.start = (sel == 3) ? start_s : 1'b0;
   assign if1.ready = (sel == 1) ? ready_s : 1'b0;
   assign if2.ready = (sel == 2) ? ready_s : 1'b0;
   assign if3.ready = (sel == 3) ? ready_s : 1'b0;

   spiral_walk_ctrl #(.GRID_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   spiral_walk_ctrl #(.GRID_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   spiral_walk_ctrl #(.GRID_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   // Routes the selected sequencer's outputs onto one set of observation signals.
   always_comb begin
      mx = '0; my = '0; mvalid = 1'b0; mlast = 1'b0; mbusy = 1'b0; mdone = 1'b0;
      case (sel)
         1: begin
            mx = {2'b00, if1.x}; my = {2'b00, if1.y};
            mvalid = if1.valid; mlast = if1.last; mbusy = if1.busy; mdone = if1.done;
         end
         2: begin
            mx = {1'b0, if2.x}; my = {1'b0, if2.y};
            mvalid = if2.valid; mlast = if2.last; mbusy = if2.busy; mdone = if2.done;
         end
         3: begin
            mx = if3.x; my = if3.y;
            mvalid = if3.valid; mlast = if3.last; mbusy = if3.busy; mdone = if3.done;
         end
         default: ;
      endcase
   end

   // Reference spiral: keep moving until the next cell is off-grid or
   // already visited, then turn clockwise. The counter-clockwise build
   // swaps x and y.
   task automatic push_model(input int n);
      bit    visited[8][8];
      int    cx, cy, dx, dy, nx, ny, t;
      beat_t b;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) visited[i][j] = 1'b0;
      cx = 0; cy = 0; dx = 1; dy = 0;
      for (int i = 0; i < n * n; i++) begin
`ifdef SPIRAL_CCW_EN
         b.x = cy[2:0]; b.y = cx[2:0];
`else
         b.x = cx[2:0]; b.y = cy[2:0];
`endif
         b.last = (i == n * n - 1);
         exp_q.push_back(b);
         visited[cx][cy] = 1'b1;
         if (i < n * n - 1) begin
            nx = cx + dx; ny = cy + dy;
            if (nx < 0 || nx >= n || ny < 0 || ny >= n || visited[nx][ny]) begin
               t = dx; dx = -dy; dy = t;
               nx = cx + dx; ny = cy + dy;
            end
            cx = nx; cy = ny;
         end
      end
   endtask

   // Runs one walk on sequencer s.
   // mode 0: ready is held high.
   // mode 1: ready follows the pattern 0,1,0,0,1.
   // mode 2: start is pulsed at beats 3 and 10 and in the done cycle.
   // mode 3: reset is applied at beat 7.
   task automatic run_walk(input int s, input int n, input int mode, input string name,
                           output logic [2:0] fx, output logic [2:0] fy);
      int         cyc, beat, busy_cnt, idx;
      bit         finished;
      bit         seen[64];
      beat_t      e;
      logic [4:0] pat;
      pat = 5'b10010;
      fx = '0; fy = '0;
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      @(negedge clk);
      sel = s; ready_s = 1'b1; start_s = 1'b0;
      #1;
      checks++;
      if (mvalid !== 1'b0 || mbusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s idle: valid=%b busy=%b, want 0 0", name, mvalid, mbusy);
      end
      start_s = 1'b1;
      push_model(n);
      cyc = 0; beat = 0; busy_cnt = 0; finished = 1'b0;
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start_s = (mode == 2) && (beat == 3 || beat == 10);
         if (mbusy) busy_cnt++;
         if (mode == 3 && beat == 7) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            checks++;
            if ({mvalid, mbusy, mdone, mlast, mx, my} !== 10'd0) begin
               errors++;
               $display("[TB] FAIL %s reset: valid=%b busy=%b done=%b last=%b x=%0d y=%0d, want all 0",
                        name, mvalid, mbusy, mdone, mlast, mx, my);
            end
            @(negedge clk);
            checks++;
            if (mvalid !== 1'b0 || mdone !== 1'b0 || mbusy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s post_reset: valid=%b busy=%b done=%b, want 0 0 0",
                        name, mvalid, mbusy, mdone);
            end
            exp_q.delete();
            return;
         end
         if (mdone) begin
            finished = 1'b1;
            checks++;
            if (mvalid !== 1'b0 || mbusy !== 1'b1 || exp_q.size() != 0) begin
               errors++;
               $display("[TB] FAIL %s done_cycle: valid=%b busy=%b pending=%0d, want 0 1 0",
                        name, mvalid, mbusy, exp_q.size());
            end
            if (mode != 1) begin
               checks++;
               if (cyc != n * n + 1 || busy_cnt != n * n + 1) begin
                  errors++;
                  $display("[TB] FAIL %s done_latency: cycle=%0d busy_cycles=%0d, want %0d",
                           name, cyc, busy_cnt, n * n + 1);
               end
            end
            if (mode == 2) start_s = 1'b1;
         end else begin
            ready_s = (mode == 1) ? pat[(cyc - 1) % 5] : 1'b1;
            checks++;
            if (mvalid !== 1'b1 || mbusy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL %s run_flags: valid=%b busy=%b, want 1 1", name, mvalid, mbusy);
            end
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL %s extra_beat: got (%0d,%0d), want no more beats", name, mx, my);
               finished = 1'b1;
            end else begin
               e = exp_q[0];
               checks++;
               if (mx !== e.x || my !== e.y || mlast !== e.last) begin
                  errors++;
                  $display("[TB] FAIL %s beat%0d: got (%0d,%0d) last=%b, want (%0d,%0d) last=%b",
                           name, beat, mx, my, mlast, e.x, e.y, e.last);
               end
               if (ready_s) begin
                  void'(exp_q.pop_front());
                  beat++;
                  fx = mx; fy = my;
                  idx = int'(mx) * n + int'(my);
                  checks++;
                  if (idx >= 64 || seen[idx]) begin
                     errors++;
                     $display("[TB] FAIL %s unique: (%0d,%0d) repeated or out of range", name, mx, my);
                  end else begin
                     seen[idx] = 1'b1;
                  end
               end
            end
         end
      end
      if (!finished) begin
         errors++;
         $display("[TB] FAIL %s timeout: no done after %0d cycles, want done", name, cyc);
      end
      @(negedge clk);
      start_s = 1'b0;
      checks++;
      if (mdone !== 1'b0 || mbusy !== 1'b0 || mvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s after_done: done=%b busy=%b valid=%b, want 0 0 0",
                  name, mdone, mbusy, mvalid);
      end
      exp_q.delete();
   endtask

   task automatic check_final(input string name, input logic [2:0] fx, input logic [2:0] fy,
                              input logic [2:0] wx, input logic [2:0] wy);
      checks++;
      if (fx !== wx || fy !== wy) begin
         errors++;
         $display("[TB] FAIL %s final: got (%0d,%0d), want (%0d,%0d)", name, fx, fy, wx, wy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_s = 1'b0; ready_s = 1'b0; sel = 0;
      repeat (2) @(negedge clk);
      for (int s = 1; s <= 3; s++) begin
         sel = s;
         #1;
         checks++;
         if ({mvalid, mbusy, mdone, mlast, mx, my} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_g%0d: valid=%b busy=%b done=%b last=%b x=%0d y=%0d, want all 0",
                     s, mvalid, mbusy, mdone, mlast, mx, my);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_clockwise();
      logic [2:0] fx, fy;
      $display("[TB] spiral walk, GRID_W=2, ready held high");
      run_walk(2, 4, 0, "walk_g2", fx, fy);
`ifdef SPIRAL_CCW_EN
      check_final("walk_g2", fx, fy, 3'd2, 3'd1);
`else
      check_final("walk_g2", fx, fy, 3'd1, 3'd2);
`endif
   endtask

   task automatic test_backpressure();
      logic [2:0] fx, fy;
      $display("[TB] backpressure, GRID_W=1");
      run_walk(1, 2, 1, "bp_g1", fx, fy);
`ifdef SPIRAL_CCW_EN
      check_final("bp_g1", fx, fy, 3'd1, 3'd0);
`else
      check_final("bp_g1", fx, fy, 3'd0, 3'd1);
`endif
   endtask

   task automatic test_start_ignored();
      logic [2:0] fx, fy;
      $display("[TB] start pulses during a walk, GRID_W=2");
      run_walk(2, 4, 2, "restart_g2", fx, fy);
   endtask

   task automatic test_mid_reset();
      logic [2:0] fx, fy;
      $display("[TB] reset at beat 7, then a fresh walk, GRID_W=2");
      run_walk(2, 4, 3, "midrst_g2", fx, fy);
      run_walk(2, 4, 0, "after_rst_g2", fx, fy);
   endtask

   task automatic test_full_grid();
      logic [2:0] fx, fy;
      $display("[TB] full walk, GRID_W=3");
      run_walk(3, 8, 0, "walk_g3", fx, fy);
`ifdef SPIRAL_CCW_EN
      check_final("walk_g3", fx, fy, 3'd4, 3'd3);
`else
      check_final("walk_g3", fx, fy, 3'd3, 3'd4);
`endif
   endtask

   initial begin
      test_reset();
      test_clockwise();
      test_backpressure();
      test_start_ignored();
      test_mid_reset();
      test_full_grid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at 200000, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/spiral_walk_ctrl.md
# spiral_walk_ctrl

Spiral-order coordinate sequencer for the Spiral design. On a start pulse it walks an N×N grid (N = 2^GRID_W) from the top-left corner inward, clockwise, one coordinate per accepted beat. It sits between the top-level control inputs and the pixel/cell datapath, whose write address it drives through a valid/ready handshake. Completion is signalled with a one-cycle done pulse.

## Interface

Parameters:
- GRID_W, default 3: coordinate width; grid is N×N with N = 2^GRID_W, GRID_W ≥ 1.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a walk; sampled only in IDLE.
- ready  in  1  downstream accepts the current coordinate.
- valid  out  1  x/y hold a coordinate to be consumed.
- x  out  GRID_W  column of current coordinate.
- y  out  GRID_W  row of current coordinate.
- last  out  1  current coordinate is the final one (beat N*N-1).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: valid=0, busy=0. If start=1: load x=0, y=0, top=0, left=0, bot=N-1, right=N-1, dir=RIGHT, count=0; go to RUN.
- RUN: valid=1. A beat is accepted when valid&&ready. Without acceptance, all registers hold.
- On acceptance with last=0, the move is:
  - RIGHT: if x==right, then top+=1, dir=DOWN, y+=1; else x+=1.
  - DOWN: if y==bot, then right-=1, dir=LEFT, x-=1; else y+=1.
  - LEFT: if x==left, then bot-=1, dir=UP, y-=1; else x-=1.
  - UP: if y==top, then left+=1, dir=RIGHT, x+=1; else y-=1.
  - In every case count+=1.
- last = (state==RUN) && (count == N*N-1). Termination is decided by count only; bounds are never checked for crossing.
- On acceptance with last=1: go to DONE.
- DONE: valid=0, done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE.
- Widths:
  - count is 2*GRID_W bits and never wraps during a walk.
  - Bounds are GRID_W bits.
  - x and y stay within [0, N-1].

## Timing

- Reset values: valid=0, last=0, busy=0, done=0, x=0, y=0; state=IDLE.
- Reset has priority over every other input, including mid-walk. After reset the block is in IDLE with no done pulse.
- start high in IDLE at edge k: valid=1 with (0,0) from the cycle after edge k.
- Each accepted beat updates x/y on the next edge. With ready held high, throughput is one coordinate per cycle.
- A walk with continuous ready takes N*N cycles in RUN plus 1 cycle in DONE.
- done is high in the cycle following the last acceptance. A start sampled in that cycle is ignored; start is accepted from the next IDLE cycle.
- x, y and last are registered or derived from registers only. There is no combinational path from ready to any output.

## Configuration

- SPIRAL_CCW_EN
  - Defined: counter-clockwise walk. The initial dir is DOWN and the turn order is DOWN→RIGHT→UP→LEFT. The sequence is the clockwise sequence with x and y swapped.
  - Undefined: clockwise walk as specified above.
  - Handshake, timing and count behaviour are identical in both builds.

## Test plan

- Clockwise, GRID_W=2, ready=1, one start pulse:
  - Required sequence: (0,0)(1,0)(2,0)(3,0)(3,1)(3,2)(3,3)(2,3)(1,3)(0,3)(0,2)(0,1)(1,1)(2,1)(2,2)(1,2).
  - last is high only on (1,2). done pulses one cycle later; busy is high for 17 cycles.
- SPIRAL_CCW_EN build, GRID_W=2: same sequence with x and y swapped; final coordinate (2,1) with last=1.
- Backpressure, GRID_W=1: ready toggles 0,1,0,0,1,...
  - x/y/last hold steady while ready=0.
  - Exactly 4 acceptances yield (0,0)(1,0)(1,1)(0,1), then done.
- start pulsed again at beats 3 and 10 of a GRID_W=2 walk: no effect; the sequence matches the first test exactly.
- rst_n low for one cycle at beat 7: next cycle valid=0, busy=0, done=0, x=y=0. A new start then restarts cleanly at (0,0).
- GRID_W=3, ready=1: 64 unique coordinates, each within [0,7]. The final coordinate is (3,4), and done is asserted 65 cycles after the start edge.
